// File: rtl/handshake_buffer_2slot.sv
// handshake_buffer_2slot: two-entry valid/ready FIFO; all outputs come from flops, cutting the ready chain.
module handshake_buffer_2slot #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    state_t                state;
    logic [DATA_WIDTH-1:0] slot [0:1];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic                  push;
    logic                  pop;
    assign push = ins_valid & ins_ready;
    assign pop  = outs_valid & outs_ready;
    assign outs = slot[rd_ptr];
    // ins_ready/outs_valid are registered alongside the state so neither depends on a live input
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= EMPTY;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            slot[0]    <= '0;
            slot[1]    <= '0;
            outs_valid <= 1'b0;
            ins_ready  <= 1'b1;
        end else begin
            if (push) begin
                slot[wr_ptr] <= ins;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case (state)
                EMPTY: if (push) begin
                    state      <= ONE;
                    outs_valid <= 1'b1;
                end
                ONE: if (push && !pop) begin
                    state     <= FULL;
                    ins_ready <= 1'b0;
                end else if (!push && pop) begin
                    state      <= EMPTY;
                    outs_valid <= 1'b0;
                end
                FULL: if (pop) begin
                    state     <= ONE;
                    ins_ready <= 1'b1;
                end
                default: begin
                    state      <= EMPTY;
                    outs_valid <= 1'b0;
                    ins_ready  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_handshake_buffer_2slot.sv
// tb_handshake_buffer_2slot: directed tests plus a token scoreboard and stall-hold monitor.
module tb_handshake_buffer_2slot;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [16:0] ins = '0;
    logic        ins_valid = 1'b0;
    logic        ins_ready;
    logic [16:0] outs;
    logic        outs_valid;
    logic        outs_ready = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [16:0] exp_q [$];
    logic [16:0] exp_tok;
    logic        prev_stall = 1'b0;
    logic [16:0] prev_outs = '0;

    handshake_buffer_2slot #(.DATA_WIDTH(17)) dut (
        .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
        .outs(outs), .outs_valid(outs_valid), .outs_ready(outs_ready)
    );

    always #5 clk = ~clk;

    // Handshakes are sampled half a cycle before the edge that commits them
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                n_cmp++;
                if (outs_valid !== 1'b1 || outs !== prev_outs) begin
                    n_err++;
                    $display("FAIL stall_hold: outs_valid=%b outs=%h, required 1 / %h", outs_valid, outs, prev_outs);
                end
            end
            if (outs_valid && outs_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_spurious: popped %h with nothing outstanding", outs);
                end else begin
                    exp_tok = exp_q.pop_front();
                    if (outs !== exp_tok) begin
                        n_err++;
                        $display("FAIL sb_order: got %h, required %h", outs, exp_tok);
                    end
                end
            end
            if (ins_valid && ins_ready)
                exp_q.push_back(ins);
            prev_stall = outs_valid && !outs_ready;
            prev_outs  = outs;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        ins_valid = 1'b1;
        ins = 17'h1ABCD;
        step();
        step();
        n_cmp++; if (outs_valid !== 1'b0) begin n_err++; $display("FAIL rst_outs_valid: got %b, required 0", outs_valid); end
        n_cmp++; if (ins_ready !== 1'b1) begin n_err++; $display("FAIL rst_ins_ready: got %b, required 1", ins_ready); end
        n_cmp++; if (outs !== 17'h0) begin n_err++; $display("FAIL rst_outs: got %h, required 0", outs); end
        rst = 1'b1;
        step();
        ins_valid = 1'b0;
        n_cmp++; if (outs_valid !== 1'b1 || outs !== 17'h1ABCD) begin n_err++; $display("FAIL rst_first_push: got %b/%h, required 1/1abcd", outs_valid, outs); end
        outs_ready = 1'b1;
        step();
        n_cmp++; if (outs_valid !== 1'b0) begin n_err++; $display("FAIL rst_drain: got %b, required 0", outs_valid); end
    endtask

    task automatic test_single();
        ins = 17'h0FA9A;
        ins_valid = 1'b1;
        outs_ready = 1'b1;
        step();
        ins_valid = 1'b0;
        n_cmp++; if (outs_valid !== 1'b1 || outs !== 17'h0FA9A) begin n_err++; $display("FAIL single_out: got %b/%h, required 1/0fa9a", outs_valid, outs); end
        step();
        n_cmp++; if (outs_valid !== 1'b0 || ins_ready !== 1'b1) begin n_err++; $display("FAIL single_empty: valid=%b ready=%b, required 0/1", outs_valid, ins_ready); end
    endtask

    task automatic test_streaming();
        ins_valid = 1'b1;
        outs_ready = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            ins = 17'(i);
            n_cmp++; if (ins_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready[%0d]: got %b, required 1", i, ins_ready); end
            step();
            n_cmp++; if (outs_valid !== 1'b1 || outs !== 17'(i)) begin n_err++; $display("FAIL stream_out[%0d]: got %b/%h, required 1/%h", i, outs_valid, outs, 17'(i)); end
        end
        ins_valid = 1'b0;
        step();
        n_cmp++; if (outs_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain: got %b, required 0", outs_valid); end
    endtask

    task automatic test_backpressure();
        outs_ready = 1'b0;
        ins_valid = 1'b1;
        ins = 17'h00A0A;
        step();
        ins = 17'h00B0B;
        n_cmp++; if (ins_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_one: got %b, required 1", ins_ready); end
        step();
        ins = 17'h00C0C;
        n_cmp++; if (ins_ready !== 1'b0) begin n_err++; $display("FAIL bp_full: got %b, required 0", ins_ready); end
        n_cmp++; if (outs_valid !== 1'b1 || outs !== 17'h00A0A) begin n_err++; $display("FAIL bp_head: got %b/%h, required 1/00a0a", outs_valid, outs); end
        for (int k = 0; k < 3; k++) begin
            ins_valid = k[0];
            ins = 17'($urandom);
            step();
            n_cmp++; if (ins_ready !== 1'b0 || outs !== 17'h00A0A) begin n_err++; $display("FAIL bp_hold[%0d]: ready=%b outs=%h, required 0/00a0a", k, ins_ready, outs); end
        end
        ins_valid = 1'b1;
        ins = 17'h00C0C;
        outs_ready = 1'b1;
        step();
        n_cmp++; if (outs !== 17'h00B0B || ins_ready !== 1'b1) begin n_err++; $display("FAIL bp_pop_a: outs=%h ready=%b, required 00b0b/1", outs, ins_ready); end
        step();
        ins_valid = 1'b0;
        n_cmp++; if (outs_valid !== 1'b1 || outs !== 17'h00C0C) begin n_err++; $display("FAIL bp_c: got %b/%h, required 1/00c0c", outs_valid, outs); end
        step();
        n_cmp++; if (outs_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain: got %b, required 0", outs_valid); end
    endtask

    task automatic test_wrap();
        logic [16:0] toks [4];
        toks = '{17'h11111, 17'h02222, 17'h13333, 17'h04444};
        outs_ready = 1'b0;
        ins_valid = 1'b1;
        ins = toks[0];
        step();
        outs_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            ins = toks[i];
            step();
            n_cmp++; if (outs_valid !== 1'b1 || ins_ready !== 1'b1 || outs !== toks[i]) begin n_err++; $display("FAIL wrap[%0d]: valid=%b ready=%b outs=%h, required 1/1/%h", i, outs_valid, ins_ready, outs, toks[i]); end
        end
        ins_valid = 1'b0;
        step();
        n_cmp++; if (outs_valid !== 1'b0) begin n_err++; $display("FAIL wrap_drain: got %b, required 0", outs_valid); end
    endtask

    task automatic test_async_reset();
        outs_ready = 1'b0;
        ins_valid = 1'b1;
        ins = 17'h15555;
        step();
        ins = 17'h06666;
        step();
        ins_valid = 1'b0;
        n_cmp++; if (ins_ready !== 1'b0 || outs_valid !== 1'b1) begin n_err++; $display("FAIL ar_full: ready=%b valid=%b, required 0/1", ins_ready, outs_valid); end
        #3 rst = 1'b0;
        #1;
        n_cmp++; if (outs_valid !== 1'b0 || ins_ready !== 1'b1 || outs !== 17'h0) begin n_err++; $display("FAIL ar_immediate: valid=%b ready=%b outs=%h, required 0/1/0", outs_valid, ins_ready, outs); end
        #2 rst = 1'b1;
        outs_ready = 1'b1;
        step();
        step();
        n_cmp++; if (outs_valid !== 1'b0) begin n_err++; $display("FAIL ar_stale: got %b, required 0", outs_valid); end
        ins_valid = 1'b1;
        ins = 17'h07777;
        step();
        ins_valid = 1'b0;
        n_cmp++; if (outs_valid !== 1'b1 || outs !== 17'h07777) begin n_err++; $display("FAIL ar_resume: got %b/%h, required 1/07777", outs_valid, outs); end
        step();
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL sb_leftover: %0d tokens outstanding, required 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_streaming();
        test_backpressure();
        test_wrap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
